// File: rtl/controle_multiciclo_if.sv
// Control-unit <-> datapath/ALU signal bundle for the multicycle MIPS core.
interface controle_multiciclo_if;
    // Instruction fields and status flags into the controller
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_pronto;
    logic       zero;
    logic       branchAtivo;

    // ALU control, datapath strobes, mux selects and status out of the controller
    logic [3:0] S;
    logic       Enable;
    logic       branch;
    logic       PCWrite;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [3:0] estado;
    logic       erro;

    modport master (
        input  opcode, funct, mem_pronto, zero, branchAtivo,
        output S, Enable, branch, PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
               RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, estado, erro
    );

    modport slave (
        output opcode, funct, mem_pronto, zero, branchAtivo,
        input  S, Enable, branch, PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
               RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, estado, erro
    );
endinterface

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS control unit: fetch/decode/execute/memory/write-back sequencer
// driving ALU control and datapath strobes. Synchronous active-low reset.
module controle_multiciclo (
    input  logic                  clock,
    input  logic                  reset,
    controle_multiciclo_if.master bus
);
    localparam int unsigned ULA_W = 4;

    typedef enum logic [3:0] {
        BUSCA      = 4'd0,
        DECODIFICA = 4'd1,
        EXEC_R     = 4'd2,
        EXEC_I     = 4'd3,
        ENDERECO   = 4'd4,
        LE_MEM     = 4'd5,
        ESC_MEM    = 4'd6,
        ESC_REG    = 4'd7,
        DESVIO     = 4'd8,
        SALTO      = 4'd9,
        ERRO       = 4'd15
    } estado_t;

    estado_t            state_q;
    logic [ULA_W-1:0]   op_ula_q;
    logic               erro_q;
    logic               rdst_q;   // write-back targets rd (R-type)
    logic               mtor_q;   // load: memory data to register, and picks LE_MEM after ENDERECO

    estado_t            dec_state;
    logic [ULA_W-1:0]   dec_op;
    logic               dec_rdst;
    logic               dec_mtor;

    // The zero flag is informational only for this controller
    logic unused_zero;
    assign unused_zero = bus.zero;

    // Instruction decode from opcode/funct; only consumed in DECODIFICA
    always_comb begin
        dec_state = ERRO;
        dec_op    = '0;
        dec_rdst  = 1'b0;
        dec_mtor  = 1'b0;
        case (bus.opcode)
            6'b000000: begin
                dec_state = EXEC_R;
                dec_rdst  = 1'b1;
                case (bus.funct)
                    6'b100000: dec_op = 4'b0000;
                    6'b100010: dec_op = 4'b0001;
                    6'b011000: dec_op = 4'b0010;
                    6'b011010: dec_op = 4'b0011;
                    6'b100100: dec_op = 4'b0100;
                    6'b100101: dec_op = 4'b0101;
                    6'b100111: dec_op = 4'b0110;
                    6'b101010: dec_op = 4'b1010;
                    default:   dec_state = ERRO;
                endcase
            end
            6'b001000: dec_state = EXEC_I;
            6'b100011: begin
                dec_state = ENDERECO;
                dec_mtor  = 1'b1;
            end
            6'b101011: dec_state = ENDERECO;
            6'b000100: begin
                dec_state = DESVIO;
                dec_op    = 4'b0111;
            end
            6'b000111: begin
                dec_state = DESVIO;
                dec_op    = 4'b1000;
            end
            6'b000110: begin
                dec_state = DESVIO;
                dec_op    = 4'b1001;
            end
            6'b000010: dec_state = SALTO;
            default:   dec_state = ERRO;
        endcase
    end

    // State sequencing plus per-instruction context latched at decode
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= BUSCA;
            op_ula_q <= '0;
            erro_q   <= 1'b0;
            rdst_q   <= 1'b0;
            mtor_q   <= 1'b0;
        end else begin
            case (state_q)
                BUSCA:      if (bus.mem_pronto) state_q <= DECODIFICA;
                DECODIFICA: begin
                    state_q  <= dec_state;
                    op_ula_q <= dec_op;
                    rdst_q   <= dec_rdst;
                    mtor_q   <= dec_mtor;
                    if (dec_state == ERRO) erro_q <= 1'b1;
                end
                EXEC_R,
                EXEC_I:     state_q <= ESC_REG;
                ENDERECO:   state_q <= mtor_q ? LE_MEM : ESC_MEM;
                LE_MEM:     if (bus.mem_pronto) state_q <= ESC_REG;
                ESC_MEM:    if (bus.mem_pronto) state_q <= BUSCA;
                ESC_REG,
                DESVIO,
                SALTO:      state_q <= BUSCA;
                ERRO:       state_q <= ERRO;
                default:    state_q <= BUSCA;
            endcase
        end
    end

    // Output decode from the current state; everything held at 0 while reset is low
    always_comb begin
        bus.S        = '0;
        bus.Enable   = 1'b0;
        bus.branch   = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.RegWrite = 1'b0;
        bus.RegDst   = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'b00;
        bus.PCSource = 2'b00;
        bus.estado   = '0;
        bus.erro     = 1'b0;
        if (reset) begin
            bus.estado = 4'(state_q);
            bus.erro   = erro_q;
            case (state_q)
                BUSCA: begin
                    bus.MemRead = 1'b1;
                    bus.Enable  = 1'b1;
                    bus.S       = 4'b1011;
                    bus.ALUSrcB = 2'b11;
                    bus.IRWrite = bus.mem_pronto;
                    bus.PCWrite = bus.mem_pronto;
                end
                EXEC_R: begin
                    bus.Enable  = 1'b1;
                    bus.S       = op_ula_q;
                    bus.ALUSrcA = 1'b1;
                end
                EXEC_I: begin
                    bus.Enable  = 1'b1;
                    bus.S       = op_ula_q;
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b01;
                end
                ENDERECO: begin
                    bus.Enable  = 1'b1;
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b01;
                end
                LE_MEM:  bus.MemRead  = 1'b1;
                ESC_MEM: bus.MemWrite = 1'b1;
                ESC_REG: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = rdst_q;
                    bus.MemtoReg = mtor_q;
                end
                DESVIO: begin
                    bus.Enable   = 1'b1;
                    bus.branch   = 1'b1;
                    bus.S        = op_ula_q;
                    bus.ALUSrcA  = 1'b1;
                    bus.PCSource = 2'b01;
                    bus.PCWrite  = bus.branchAtivo;
                end
                SALTO: begin
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = 2'b10;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multicycle control unit for the MIPS core: the instruction-side partner of the ALU. Sequences each instruction through fetch, decode, execute, memory and write-back states. Drives the ALU's operation select, enable and branch request, and consumes the ALU's zero/branch-taken flags to steer PC, memory, IR and register-file strobes. Sits between the instruction register and the datapath muxes; memory accesses use a ready handshake.

## Interface
- No parameters. Widths are fixed by the 32-bit datapath and the 6-bit MIPS opcode/funct fields.
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-low; sampled on the rising edge of clock
- opcode  in  6  IR[31:26], stable from the cycle after IRWrite
- funct  in  6  IR[5:0]
- mem_pronto  in  1  memory ready; completes the current MemRead/MemWrite access in the cycle it is 1
- zero  in  1  ALU zero/condition flag (monitor only)
- branchAtivo  in  1  ALU branch-taken flag
- S  out  4  ALU operation select
- Enable  out  1  ALU enable
- branch  out  1  branch request to ALU
- PCWrite, IRWrite, MemRead, MemWrite, RegWrite  out  1 each  datapath strobes
- RegDst  out  1  0 = rt, 1 = rd
- MemtoReg  out  1  0 = ALU result, 1 = memory data
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = register B, 01 = sign-extended immediate, 10 = 0, 11 = PC
- PCSource  out  2  00 = ALU result, 01 = branch target, 10 = jump target
- estado  out  4  current state code
- erro  out  1  sticky illegal-instruction flag

## Operation
- States and codes: BUSCA 0, DECODIFICA 1, EXEC_R 2, EXEC_I 3, ENDERECO 4, LE_MEM 5, ESC_MEM 6, ESC_REG 7, DESVIO 8, SALTO 9, ERRO 15. Unused codes go to BUSCA.
- Decode in DECODIFICA latches op_ula (4 bits) and the next state.
  - R-type (opcode 000000), by funct:
    - add 100000 → 0000
    - sub 100010 → 0001
    - mult 011000 → 0010
    - div 011010 → 0011
    - and 100100 → 0100
    - or 100101 → 0101
    - not 100111 → 0110
    - slt 101010 → 1010
    - next state EXEC_R
  - addi 001000 → 0000, EXEC_I
  - lw 100011 / sw 101011 → 0000, ENDERECO
  - beq 000100 → 0111, DESVIO
  - bgt 000111 → 1000, DESVIO
  - ble 000110 → 1001, DESVIO
  - j 000010 → SALTO
  - any other opcode or funct → ERRO
- BUSCA:
  - MemRead=1, Enable=1, S=1011, ALUSrcB=11, PCSource=00.
  - IRWrite=PCWrite=mem_pronto.
  - Stay in BUSCA while mem_pronto=0; go to DECODIFICA when mem_pronto=1.
- DECODIFICA: all strobes 0, Enable=0.
- EXEC_R: Enable=1, S=op_ula, ALUSrcA=1, ALUSrcB=00. Next ESC_REG with RegDst=1.
- EXEC_I: as EXEC_R but ALUSrcB=01. Next ESC_REG with RegDst=0.
- ENDERECO: Enable=1, S=0000, ALUSrcA=1, ALUSrcB=01. Next LE_MEM (lw) or ESC_MEM (sw).
- The datapath captures the ALU result at the end of every EXEC_R, EXEC_I and ENDERECO cycle.
- LE_MEM: MemRead=1; wait for mem_pronto, then ESC_REG with MemtoReg=1, RegDst=0.
- ESC_MEM: MemWrite=1; wait for mem_pronto, then BUSCA.
- ESC_REG: RegWrite=1 for exactly one cycle, then BUSCA.
- DESVIO:
  - Enable=1, branch=1, S=op_ula, ALUSrcA=1, ALUSrcB=00, PCSource=01.
  - PCWrite=branchAtivo (same-cycle, Mealy).
  - Next BUSCA.
- SALTO: PCWrite=1, PCSource=10, then BUSCA.
- ERRO: erro=1, all strobes and Enable 0. Remains in ERRO until reset.

## Timing
- Reset: while reset=0 at a rising edge, the next state is BUSCA, op_ula=0000 and erro=0.
  - While reset is low, every strobe, Enable and branch is forced to 0.
  - Reset values: S=0000, all mux selects 0, estado=0.
- Reset asserted mid-instruction (including memory waits) aborts the instruction with no further strobe. Fetch restarts on the first edge with reset=1.
- Cycle counts with mem_pronto=1 immediately:
  - R-type / addi: 4
  - lw: 5
  - sw: 4
  - branches: 3
  - j: 3
- Each cycle of mem_pronto=0 adds one cycle.
- Strobes are one cycle wide, except MemRead/MemWrite, which stay high through the wait.
- opcode/funct are ignored outside DECODIFICA.

## Test plan
- Reset low for 2 cycles mid-LE_MEM → estado=0 and all strobes 0 during reset; the first cycle after release shows BUSCA with MemRead=1, S=1011.
- add (opcode 0, funct 100000), mem_pronto=1 → estado 0,1,2,7,0; S=0000 with ALUSrcA=1 in state 2; RegWrite=1 with RegDst=1 for exactly one cycle.
- lw with mem_pronto held 0 for 3 cycles in LE_MEM → MemRead high for 4 cycles; then ESC_REG with MemtoReg=1, RegWrite=1; total 8 cycles.
- beq with branchAtivo=1, then a second beq with branchAtivo=0 → DESVIO shows S=0111, branch=1; PCWrite is 1 then 0; both return to BUSCA after 3 cycles.
- Illegal opcode 111111 → estado=15 and erro=1 from the cycle after DECODIFICA, holding for 20 cycles with no strobes; reset clears erro.
- j (000010) → PCWrite=1, PCSource=10 in SALTO; Enable=0 throughout except in BUSCA.
